// File: rtl/bus_interface_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_interface_unit_pkg
// Description : Shared definitions for the core: ALU op codes and the
//               bus-interface-unit state encoding and bus-phase constants.
// Contents    : alu_op_t     - ALU operation select
//               biu_state_t  - bus interface unit FSM states
//               c_rw_read / c_rw_write - levels of the rw_pin strobe
// Revision    : 1.0 - initial release
// ============================================================================
package bus_interface_unit_pkg;

    // ALU operation select used by the execute stage.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    // Bus interface unit transfer phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } biu_state_t;

    // rw_pin levels; the bus idles in the read direction.
    localparam logic c_rw_read  = 1'b1;
    localparam logic c_rw_write = 1'b0;

endpackage : bus_interface_unit_pkg
`default_nettype wire

// File: rtl/bus_interface_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_interface_unit
// Description : Bridges single-cycle core requests onto a narrow multiplexed
//               pin bus: the address goes out LSB slice first with ale high,
//               followed by one data phase that may be stretched by rdy_pin
//               and is cut short by a saturating wait-state timeout.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               req, we, addr, wdata - core request (sampled in IDLE)
//               busy, ack, err, rdata- core status / read data
//               pin_out, pin_oe      - multiplexed address/write-data pins
//               pin_in               - read-data pins
//               rw_pin, ale, rdy_pin - bus direction, address strobe, ready
// Revision    : 1.0 - initial release
// ============================================================================
module bus_interface_unit
    import bus_interface_unit_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int PIN_W    = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [PIN_W-1:0]  pin_out,
    input  logic [PIN_W-1:0]  pin_in,
    output logic [PIN_W-1:0]  pin_oe,
    output logic              rw_pin,
    output logic              ale,
    input  logic              rdy_pin
);

    localparam int NBEATS = ADDR_W / PIN_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int IDX_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(NBEATS - 1);
    localparam logic [WAIT_W-1:0] c_max_wait  = WAIT_W'(MAX_WAIT);

    generate
        if ((ADDR_W % PIN_W) != 0) begin : g_chk_addr_w
            $error("ADDR_W must be a multiple of PIN_W");
        end
        if (DATA_W != PIN_W) begin : g_chk_data_w
            $error("DATA_W must equal PIN_W");
        end
    endgenerate

    biu_state_t          r_state;
    biu_state_t          w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [BEAT_W-1:0]   r_beat;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_capture;
    logic                w_beat_inc;
    logic                w_wait_inc;
    logic                w_timeout_set;
    logic                w_rdata_load;
    logic [IDX_W-1:0]    w_slice_base;

    // Bit offset of the address slice for the current beat.
    assign w_slice_base = IDX_W'(r_beat) * IDX_W'(PIN_W);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_beat_inc    = 1'b0;
        w_wait_inc    = 1'b0;
        w_timeout_set = 1'b0;
        w_rdata_load  = 1'b0;
        busy          = 1'b1;
        ack           = 1'b0;
        err           = 1'b0;
        pin_out       = '0;
        pin_oe        = '0;
        ale           = 1'b0;
        rw_pin        = c_rw_read;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                ale     = 1'b1;
                rw_pin  = r_we ? c_rw_write : c_rw_read;
                pin_out = r_addr[w_slice_base +: PIN_W];
                if (r_beat == c_last_beat) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_beat_inc = 1'b1;
                end
            end

            ST_DATA: begin
                rw_pin = r_we ? c_rw_write : c_rw_read;
                if (r_we) begin
                    pin_out = r_wdata;
                    pin_oe  = '1;
                end
                // The counter only advances on a stretched cycle; once it sits
                // at MAX_WAIT a further not-ready cycle ends the transfer.
                if (rdy_pin) begin
                    w_rdata_load = ~r_we;
                    w_state_nxt  = ST_DONE;
                end else if (r_wait == c_max_wait) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            ST_DONE: begin
                ack         = 1'b1;
                err         = r_timeout;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_beat    <= '0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (w_capture) begin
                r_addr    <= addr;
                r_we      <= we;
                r_wdata   <= wdata;
                r_beat    <= '0;
                r_wait    <= '0;
                r_timeout <= 1'b0;
            end
            if (w_beat_inc) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_wait_inc) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            if (w_rdata_load) begin
                r_rdata <= pin_in;
            end
        end
    end

    assign rdata = r_rdata;

endmodule : bus_interface_unit
`default_nettype wire

// File: tb/tb_bus_interface_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_interface_unit
// Description : Directed self-checking bench for bus_interface_unit. Two
//               instances share the pin-side inputs: a default 16-bit-address
//               unit and a 24-bit-address unit. Expected completions are
//               queued when a request is issued and compared on ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interface_unit;

    localparam int MAXW = 15;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a;
    logic        req_b;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  pin_in;
    logic        rdy_pin;

    logic        a_busy, a_ack, a_err, a_rw, a_ale;
    logic [7:0]  a_rdata, a_pin_out, a_pin_oe;
    logic        b_busy, b_ack, b_err, b_rw, b_ale;
    logic [7:0]  b_rdata, b_pin_out, b_pin_oe;

    int          n_total = 0;
    int          n_pass  = 0;
    exp_t        sb[$];
    logic [7:0]  model_rdata [2];

    always #5 clk = ~clk;

    bus_interface_unit u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .we      (we),
        .addr    (addr[15:0]),
        .wdata   (wdata),
        .busy    (a_busy),
        .ack     (a_ack),
        .err     (a_err),
        .rdata   (a_rdata),
        .pin_out (a_pin_out),
        .pin_in  (pin_in),
        .pin_oe  (a_pin_oe),
        .rw_pin  (a_rw),
        .ale     (a_ale),
        .rdy_pin (rdy_pin)
    );

    bus_interface_unit #(.ADDR_W(24)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (b_busy),
        .ack     (b_ack),
        .err     (b_err),
        .rdata   (b_rdata),
        .pin_out (b_pin_out),
        .pin_in  (pin_in),
        .pin_oe  (b_pin_oe),
        .rw_pin  (b_rw),
        .ale     (b_ale),
        .rdy_pin (rdy_pin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Checks every output of one instance against its idle/reset values.
    task automatic chk_idle(input bit sel, input string tag, input logic [7:0] exp_rdata);
        chk({tag, "_busy"},  sel ? b_busy    : a_busy,    0);
        chk({tag, "_ack"},   sel ? b_ack     : a_ack,     0);
        chk({tag, "_err"},   sel ? b_err     : a_err,     0);
        chk({tag, "_rdata"}, sel ? b_rdata   : a_rdata,   exp_rdata);
        chk({tag, "_pout"},  sel ? b_pin_out : a_pin_out, 0);
        chk({tag, "_oe"},    sel ? b_pin_oe  : a_pin_oe,  0);
        chk({tag, "_ale"},   sel ? b_ale     : a_ale,     0);
        chk({tag, "_rw"},    sel ? b_rw      : a_rw,      1);
    endtask

    // One transfer, entered and left on a falling edge. nwait = not-ready
    // DATA cycles before rdy_pin rises; tmo keeps rdy_pin low throughout.
    task automatic xfer(input bit sel, input bit w, input logic [23:0] ad,
                        input logic [7:0] wd, input int nwait,
                        input logic [7:0] pv, input bit tmo, input bit hold);
        int   nb;
        int   ndata;
        int   d;
        bit   done;
        exp_t e;
        exp_t got;
        logic o_busy, o_ack, o_err, o_rw, o_ale;
        logic [7:0] o_rdata, o_pout, o_oe;

        nb    = sel ? 3 : 2;
        ndata = tmo ? (MAXW + 1) : (nwait + 1);
        if (!w && !tmo) model_rdata[sel] = pv;
        e.err   = tmo;
        e.rdata = model_rdata[sel];
        e.lat   = nb + ndata + 1;
        sb.push_back(e);

        we = w; addr = ad; wdata = wd; pin_in = pv; rdy_pin = 1'b0;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        done = 1'b0;

        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            o_busy  = sel ? b_busy    : a_busy;
            o_ack   = sel ? b_ack     : a_ack;
            o_err   = sel ? b_err     : a_err;
            o_rw    = sel ? b_rw      : a_rw;
            o_ale   = sel ? b_ale     : a_ale;
            o_rdata = sel ? b_rdata   : a_rdata;
            o_pout  = sel ? b_pin_out : a_pin_out;
            o_oe    = sel ? b_pin_oe  : a_pin_oe;

            if (cyc <= nb) begin
                rdy_pin = 1'b0;
                chk("addr_ale",  o_ale,  1);
                chk("addr_pout", o_pout, ad[(cyc-1)*8 +: 8]);
                chk("addr_rw",   o_rw,   !w);
                chk("addr_oe",   o_oe,   0);
                chk("addr_busy", o_busy, 1);
                chk("addr_ack",  o_ack,  0);
            end else if (o_ack) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("ack_cycle",  cyc,     got.lat);
                    chk("done_err",   o_err,   got.err);
                    chk("done_rdata", o_rdata, got.rdata);
                end
                chk("done_pout", o_pout, 0);
                chk("done_oe",   o_oe,   0);
                chk("done_ale",  o_ale,  0);
                chk("done_rw",   o_rw,   1);
                chk("done_busy", o_busy, 1);
                done = 1'b1;
            end else begin
                d = cyc - nb;
                rdy_pin = !tmo && (d > nwait);
                chk("data_busy", o_busy, 1);
                chk("data_oe",   o_oe,   w ? 8'hFF : 8'h00);
                chk("data_rw",   o_rw,   !w);
                chk("data_ale",  o_ale,  0);
                chk("data_err",  o_err,  0);
                if (w) chk("data_pout", o_pout, wd);
            end
        end
        chk("ack_seen", done, 1);

        // Cycle after DONE is always IDLE, even with req still high.
        rdy_pin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_busy", sel ? b_busy : a_busy, 0);
        chk("post_ack",  sel ? b_ack  : a_ack,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; pin_in = '0; rdy_pin = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;

        // Reset state, with req asserted to show reset wins.
        @(negedge clk);
        req_a = 1'b1; req_b = 1'b1; rdy_pin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle(1'b0, "rst_a", 8'h00);
        chk_idle(1'b1, "rst_b", 8'h00);
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; rdy_pin = 1'b0;

        // Default instance: read, write, wait states, timeout.
        xfer(1'b0, 1'b0, 24'h00BEEF, 8'h00, 0, 8'h5A, 1'b0, 1'b0);
        xfer(1'b0, 1'b1, 24'h001234, 8'hC3, 0, 8'h00, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 24'h00A55A, 8'h00, 3, 8'h3C, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, 24'h000F0F, 8'h00, 0, 8'hA5, 1'b1, 1'b0);

        // req held through a transfer: new transfer only after an IDLE cycle.
        xfer(1'b0, 1'b1, 24'h00ABCD, 8'h77, 1, 8'h00, 1'b0, 1'b1);
        xfer(1'b0, 1'b0, 24'h004321, 8'h00, 0, 8'h96, 1'b0, 1'b0);

        // Reset in the DATA phase of a write.
        we = 1'b1; addr = 24'h00CAFE; wdata = 8'hE7; rdy_pin = 1'b0; req_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            req_a = 1'b0;
        end
        chk("pre_rst_oe", a_pin_oe, 8'hFF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_rdata[0] = 8'h00;
        model_rdata[1] = 8'h00;
        chk_idle(1'b0, "midrst", 8'h00);
        rdy_pin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_noack", a_ack, 0);
        end
        rdy_pin = 1'b0;

        // 24-bit address instance: three address beats.
        xfer(1'b1, 1'b0, 24'h123456, 8'h00, 0, 8'h9C, 1'b0, 1'b0);
        xfer(1'b1, 1'b1, 24'hABCDEF, 8'h11, 2, 8'h00, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bus_interface_unit
`default_nettype wire
